// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// access-size encodings, requester id and the misalignment predicate.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] F3_SH    = 3'b001;
  localparam logic [2:0] F3_SW_LW = 3'b010;

  // Requester id: 0 = pipeline MEM stage, 1 = debug/program loader.
  typedef logic owner_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lsb);
    return ((funct3 == F3_SW_LW) && (lsb != 2'b00)) ||
           ((funct3 == F3_SH) && lsb[0]);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of dmem_arbiter. The slave modport
// is the arbiter; master is everything around it (two requesters + memory).
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [DM_ADDRESS-1:0] addr0, addr1;
  logic [DATA_W-1:0]     wdata0, wdata1;
  logic [2:0]            funct3_0, funct3_1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_W-1:0]     rdata0, rdata1;
  logic                  err0, err1;
  logic                  busy;
  logic                  MemRead, MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic [2:0]            Funct3;
  logic [DATA_W-1:0]     rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1, rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, busy,
           MemRead, MemWrite, a, wd, Funct3
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1, rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, busy,
           MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. ptr names the requester favoured when both
// request; on advance it moves to the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic ptr;

  always_comb begin
    // NOTE: default assignment first so no path leaves gnt_onehot unassigned (no latch).
    gnt_onehot = 2'b00;
    case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      2'b11:   gnt_onehot = ptr ? 2'b10 : 2'b01;
      default: gnt_onehot = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n)     ptr <= 1'b0;
    else if (advance) ptr <= gnt_onehot[0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the data memory port, one access in flight.
// Optional misaligned-access trap: define DMEM_ARB_MISALIGN_CHK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  typedef struct packed {
    logic                  we;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
    owner_t                owner;
  } payload_t;

  state_t            state_q, state_d;
  payload_t          win, pl_q;
  logic [1:0]        gnt_oh;
  logic              take;
  logic              win_mis;
  logic [1:0]        rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q [2];

  // A grant is only issued from IDLE; the picker pointer moves with it.
  assign take = (state_q == IDLE) && (bus.req0 || bus.req1);

  rr_arb2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        ({bus.req1, bus.req0}),
    .advance    (take),
    .gnt_onehot (gnt_oh)
  );

  always_comb begin
    win = {bus.we0, bus.addr0, bus.wdata0, bus.funct3_0, 1'b0};
    if (gnt_oh[1]) win = {bus.we1, bus.addr1, bus.wdata1, bus.funct3_1, 1'b1};
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign win_mis = is_misaligned(win.funct3, win.addr[1:0]);
`else
  assign win_mis = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a trapped misaligned access never leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take && !win_mis) state_d = ISSUE;
      ISSUE:   state_d = pl_q.we ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pl_q <= '0;
    else if (take) pl_q <= win;
  end

  // Response path: load data is captured at the end of RESP, or forced to 0
  // when a misaligned load is trapped; rvalid/err pulse the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      // NOTE: rdata is a two-entry register file, not a RAM, so it is reset with everything else.
      rdata_q  <= '{default: '0};
    end else begin
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      if (state_q == RESP) begin
        rvalid_q[pl_q.owner] <= 1'b1;
        rdata_q[pl_q.owner]  <= bus.rd;
      end
      if (take && win_mis) begin
        err_q[win.owner] <= 1'b1;
        if (!win.we) begin
          rvalid_q[win.owner] <= 1'b1;
          rdata_q[win.owner]  <= '0;
        end
      end
    end
  end

  // Outputs: memory controls are only active in ISSUE/RESP.
  always_comb begin
    bus.gnt0     = take && gnt_oh[0];
    bus.gnt1     = take && gnt_oh[1];
    bus.busy     = (state_q != IDLE);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.a        = '0;
    bus.wd       = '0;
    bus.Funct3   = '0;
    case (state_q)
      ISSUE: begin
        bus.MemWrite = pl_q.we;
        bus.MemRead  = !pl_q.we;
        bus.a        = pl_q.addr;
        bus.wd       = pl_q.wdata;
        bus.Funct3   = pl_q.funct3;
      end
      RESP: begin
        bus.MemRead  = 1'b1;
        bus.a        = pl_q.addr;
        bus.wd       = pl_q.wdata;
        bus.Funct3   = pl_q.funct3;
      end
      default: ;
    endcase
  end

  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];
  assign bus.err0    = err_q[0];
  assign bus.err1    = err_q[1];

endmodule
